instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Parametrised successor to the single load-enabled instruction register.
- Holds up to DEPTH fetched instructions, each tagged with its PC, between instruction memory and decode.
- Fetch continues while decode stalls.
- Decode sees the oldest entry first-word-fall-through. A branch/exception flush discards all entries in one cycle.

Parameters:
- DATA_W, 32, instruction width in bits.
- PC_W, 32, width of the PC tag stored with each instruction.
- DEPTH, 4, number of entries. Power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears queue state.
- flush  input  1  synchronous discard of all entries.
- push_valid  input  1  fetch side offers an instruction.
- push_ready  output  1  queue accepts push this cycle.
- push_instr  input  DATA_W  fetched instruction.
- push_pc  input  PC_W  PC of push_instr.
- pop_valid  output  1  head entry is valid.
- pop_ready  input  1  decode consumes the head entry this cycle.
- pop_instr  output  DATA_W  head instruction; 0 (NOP) when empty.
- pop_pc  output  PC_W  head PC; 0 when empty.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- While reset is asserted:
  - wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, pop_valid = 0, push_ready = 1.
  - pop_instr = 0, pop_pc = 0.
  - Storage array is not cleared.
- Push handshake: a push occurs on a rising edge with push_valid && push_ready.
- push_ready = !full, combinational. It does not depend on pop_ready: a full queue refuses a push even while popping.
- Pop handshake: a pop occurs on a rising edge with pop_valid && pop_ready.
- pop_valid = !empty. pop_ready while empty has no effect.
- Latency: an entry pushed at edge N is visible on pop_instr/pop_pc after edge N, i.e. in cycle N+1. There is no same-cycle bypass from push to pop.
- Head output:
  - pop_instr/pop_pc are driven from storage[rd_ptr], masked to 0 when empty.
  - The head holds its value until popped, matching the hold-when-not-loaded rule of the instruction register.
- Simultaneous push and pop (0 < count < DEPTH): both pointers advance and count is unchanged.
- Pointers:
  - log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
  - full/empty are derived from count, not from pointer equality.
- Flush:
  - On the edge with flush = 1: pointers go to 0 and count goes to 0.
  - Any push or pop in that cycle is discarded.
  - The next cycle shows empty = 1 and pop_instr = 0.
  - Priority: reset > flush > push/pop.
- Reset mid-operation (asynchronous assertion while the queue holds entries): outputs go to reset values immediately, without waiting for an edge. Contents are lost.
- Count arithmetic: count_next = count + push_fire - pop_fire, never outside 0..DEPTH.

Decomposition:
- Shared package ifq_pkg:
  - IFQ_NOP = 32'h0000_0000 (sll $0,$0,0).
  - Default widths IFQ_DATA_W = 32 and IFQ_PC_W = 32.
  - Function clog2 for pointer sizing.
- One natural sub-module, ifq_ptr: a parametrised wrapping pointer with increment enable, synchronous clear, and async reset. It is instantiated twice, once for rd_ptr and once for wr_ptr.
- Storage, count, and handshake logic live in the top level.

Test Plan:
- Reset: assert reset mid-cycle with 2 entries held -> immediately count = 0, empty = 1, pop_valid = 0, pop_instr = 0, push_ready = 1.
- Fill and drain, DEPTH = 4:
  - Push 0x2008_0001..0x2008_0004 (PC 0x0, 0x4, 0x8, 0xC) with pop_ready = 0 -> full = 1, push_ready = 0, count = 4.
  - A 5th push of 0xDEAD_BEEF is refused.
  - Pop 4 -> entries emerge in order with matching PCs, then empty = 1.
- Wrap-around: run 10 cycles of continuous push+pop, starting from count = 1 -> count stays 1. Pointers wrap past 3 and the data order is preserved.
- Full with simultaneous pop: at count = 4, assert push_valid and pop_ready together -> pop accepted, push refused, count = 3, and the refused word never appears.
- Flush: at count = 3, assert flush together with push_valid and pop_ready -> next cycle count = 0, empty = 1. The pushed word is absent after subsequent pushes.
- Latency: push 0x0000_0020 into an empty queue at edge N -> pop_valid = 0 in cycle N and pop_valid = 1 with pop_instr = 0x0000_0020 in cycle N+1.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue.
// Contents: the NOP encoding, default payload widths and a ceiling-log2 helper
// used to size the queue's pointers.
package ifq_pkg;

    // sll $0,$0,0 -- the word decode sees when the queue is empty
    localparam logic [31:0] IFQ_NOP = 32'h0000_0000;

    localparam int unsigned IFQ_DATA_W = 32;
    localparam int unsigned IFQ_PC_W   = 32;

    // Ceiling log2, with a minimum result of 1 so a pointer is never zero-width
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ifq_ptr.sv
// Wrapping queue pointer.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high; pointer to 0
//   clr   - synchronous clear, takes priority over inc
//   inc   - advance by one, wrapping naturally at 2**W
//   ptr   - current pointer value
module ifq_ptr #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Power-of-two depth lets the pointer wrap by plain overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue between instruction memory and decode.
// Stores up to DEPTH instructions tagged with their PC; the oldest entry is
// presented first-word-fall-through. A flush empties the queue in one cycle.
// Ports:
//   clk, reset           - clock (rising edge), async active-high reset
//   flush                - synchronous discard of every entry
//   push_valid/ready     - fetch-side handshake; push_instr/push_pc payload
//   pop_valid/ready      - decode-side handshake; pop_instr/pop_pc head payload
//   count, full, empty   - occupancy status
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DATA_W = IFQ_DATA_W,
    parameter int unsigned PC_W   = IFQ_PC_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_instr,
    input  logic [PC_W-1:0]   push_pc,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_instr,
    output logic [PC_W-1:0]   pop_pc,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = clog2(DEPTH);

    logic [DATA_W-1:0] mem_instr [DEPTH];
    logic [PC_W-1:0]   mem_pc    [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_fire;
    logic              pop_fire;

    // Status comes from the count register, never from pointer equality
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign push_ready = !full;
    assign pop_valid  = !empty;

    assign push_fire = push_valid && push_ready;
    assign pop_fire  = pop_valid && pop_ready;

    // Head is masked to NOP/0 while empty, so reset clears it without an edge
    assign pop_instr = empty ? DATA_W'(IFQ_NOP) : mem_instr[rd_ptr];
    assign pop_pc    = empty ? '0 : mem_pc[rd_ptr];

    ifq_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (push_fire),
        .ptr   (wr_ptr)
    );

    ifq_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (pop_fire),
        .ptr   (rd_ptr)
    );

    // Storage is deliberately not reset; the count masks stale contents
    always_ff @(posedge clk) begin
        if (push_fire && !flush) begin
            mem_instr[wr_ptr] <= push_instr;
            mem_pc[wr_ptr]    <= push_pc;
        end
    end

    // Occupancy; handshakes guarantee it stays within 0..DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(push_fire) - CNT_W'(pop_fire);
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a scoreboard: accepted pushes are
// queued as expected entries, and a monitor compares every popped head.
module tb_instr_fetch_queue;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              push_valid;
    logic              push_ready;
    logic [DATA_W-1:0] push_instr;
    logic [PC_W-1:0]   push_pc;
    logic              pop_valid;
    logic              pop_ready;
    logic [DATA_W-1:0] pop_instr;
    logic [PC_W-1:0]   pop_pc;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] instr;
    } ent_t;

    ent_t exp_q[$];
    ent_t mon_e;
    int   tests = 0;
    int   fails = 0;

    instr_fetch_queue #(
        .DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_instr (push_instr),
        .push_pc    (push_pc),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_instr  (pop_instr),
        .pop_pc     (pop_pc),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    // Monitor: every head that will be consumed at the next edge must match
    // the oldest expected entry
    always @(negedge clk) begin
        if (!reset && !flush && pop_valid && pop_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got instr=%h pc=%h, required no entry", pop_instr, pop_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if (pop_instr !== mon_e.instr || pop_pc !== mon_e.pc) begin
                    fails++;
                    $display("FAIL pop_data: got instr=%h pc=%h, required instr=%h pc=%h",
                             pop_instr, pop_pc, mon_e.instr, mon_e.pc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Occupancy flags are all implied by the hand-computed count
    task automatic check_status(input string tag, input int exp_cnt);
        chk({tag, ".count"},      32'(count),      32'(exp_cnt));
        chk({tag, ".full"},       32'(full),       32'(exp_cnt == DEPTH));
        chk({tag, ".empty"},      32'(empty),      32'(exp_cnt == 0));
        chk({tag, ".pop_valid"},  32'(pop_valid),  32'(exp_cnt != 0));
        chk({tag, ".push_ready"}, 32'(push_ready), 32'(exp_cnt != DEPTH));
    endtask

    // Drive one cycle's inputs; acc says whether the push is expected to land
    task automatic set_in(input logic pv, input logic [31:0] instr, input logic [31:0] pc,
                          input logic pr, input logic fl, input logic acc);
        push_valid = pv;
        push_instr = instr;
        push_pc    = pc;
        pop_ready  = pr;
        flush      = fl;
        if (fl) exp_q.delete();
        if (acc) exp_q.push_back('{pc: pc, instr: instr});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_status("reset", 0);
        chk("reset.pop_instr", pop_instr, 32'h0);
        chk("reset.pop_pc", pop_pc, 32'h0);
        reset = 1'b0;
        step();

        // Latency: no bypass in cycle N, visible in cycle N+1
        set_in(1'b1, 32'h0000_0020, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
        #1;
        chk("lat.pop_valid_n", 32'(pop_valid), 32'h0);
        step();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("lat.pop_valid_n1", 32'(pop_valid), 32'h1);
        chk("lat.pop_instr_n1", pop_instr, 32'h0000_0020);
        chk("lat.pop_pc_n1", pop_pc, 32'h0000_0100);
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        check_status("lat_drain", 0);

        // Fill to DEPTH with decode stalled
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'h2008_0001 + 32'(i), 32'(i * 4), 1'b0, 1'b0, 1'b1);
            step();
        end
        check_status("fill", 4);
        set_in(1'b1, 32'hDEAD_BEEF, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
        step();
        check_status("refused", 4);
        chk("hold.pop_instr", pop_instr, 32'h2008_0001);

        // Drain in order (monitor checks data and PCs)
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            step();
        end
        check_status("drain", 0);
        chk("drain.pop_instr", pop_instr, 32'h0);

        // Full with simultaneous push and pop: only the pop lands
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'h3000_0000 + 32'(i), 32'h40 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
            step();
        end
        check_status("refill", 4);
        set_in(1'b1, 32'hBAD0_0001, 32'h0000_0099, 1'b1, 1'b0, 1'b0);
        step();
        check_status("full_pop", 3);

        // Flush beats a concurrent push and pop
        set_in(1'b1, 32'hBAD0_0002, 32'h0000_009C, 1'b1, 1'b1, 1'b0);
        step();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_status("flush", 0);
        chk("flush.pop_instr", pop_instr, 32'h0);
        set_in(1'b1, 32'h4000_0001, 32'h0000_0080, 1'b0, 1'b0, 1'b1);
        step();
        set_in(1'b1, 32'h4000_0002, 32'h0000_0084, 1'b0, 1'b0, 1'b1);
        step();
        check_status("post_flush", 2);
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            step();
        end
        check_status("post_flush_drain", 0);

        // Wrap-around: continuous push+pop at count 1
        set_in(1'b1, 32'h5000_0000, 32'h0000_0200, 1'b0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 32'h5000_0001 + 32'(i), 32'h204 + 32'(i * 4), 1'b1, 1'b0, 1'b1);
            step();
            check_status("wrap", 1);
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        check_status("wrap_drain", 0);

        // Asynchronous reset mid-cycle with two entries held
        set_in(1'b1, 32'h6000_0001, 32'h0000_0300, 1'b0, 1'b0, 1'b1);
        step();
        set_in(1'b1, 32'h6000_0002, 32'h0000_0304, 1'b0, 1'b0, 1'b1);
        step();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_status("pre_reset", 2);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        check_status("async_reset", 0);
        chk("async_reset.pop_instr", pop_instr, 32'h0);
        chk("async_reset.pop_pc", pop_pc, 32'h0);
        step();
        reset = 1'b0;
        step();
        check_status("after_reset", 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
